// File: rtl/mod5_onehot_tracker_if.sv
// mod5_onehot_tracker_if: serial bit handshake plus result bus of the mod-5 tracker.
// master: drives bit_valid/bit_in/sof/eof, observes bit_ready and the result signals.
// slave:  the tracker; accepts bits and drives bit_ready, rem_onehot, rem_en,
//         result_valid, divisible, overflow, bit_count.
interface mod5_onehot_tracker_if #(
    parameter int CNT_W = 6
);
    logic             bit_valid;
    logic             bit_in;
    logic             sof;
    logic             eof;
    logic             bit_ready;
    logic [7:0]       rem_onehot;
    logic             rem_en;
    logic             result_valid;
    logic             divisible;
    logic             overflow;
    logic [CNT_W-1:0] bit_count;
    modport master (
        output bit_valid, bit_in, sof, eof,
        input  bit_ready, rem_onehot, rem_en, result_valid, divisible, overflow, bit_count
    );
    modport slave (
        input  bit_valid, bit_in, sof, eof,
        output bit_ready, rem_onehot, rem_en, result_valid, divisible, overflow, bit_count
    );
endinterface

// File: rtl/mod5_onehot_tracker.sv
// mod5_onehot_tracker: tracks the mod-5 remainder of a framed MSB-first bit stream as a one-hot vector.
// Ports: clk, rst (sync, active-high); bus_io (slave modport) carries the bit_valid/bit_ready
// handshake with bit_in/sof/eof, and the registered results rem_onehot/rem_en (to the 8-to-3
// encoder), result_valid pulse, divisible, overflow and the saturating bit_count.
module mod5_onehot_tracker #(
    parameter int MAX_BITS = 32,
    parameter int CNT_W    = 6
) (
    input logic                  clk,
    input logic                  rst,
    mod5_onehot_tracker_if.slave bus_io
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BITS);
    state_t           state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, en_q, en_d, div_q, div_d, rv_q, rv_d, rdy_q, rdy_d;
    logic             acc, sat;
    // r' = (2r + b) mod 5, expressed directly on the one-hot bits
    function automatic logic [7:0] next_rem(input logic [7:0] r, input logic b);
        return {3'b000,
                (r[2] & ~b) | (r[4] & b),
                (r[1] & b)  | (r[4] & ~b),
                (r[1] & ~b) | (r[3] & b),
                (r[0] & b)  | (r[3] & ~b),
                (r[0] & ~b) | (r[2] & b)};
    endfunction
    assign acc = bus_io.bit_valid && rdy_q;
    assign sat = cnt_q == MAX_C;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= 8'h01;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
            div_q   <= 1'b0;
            rv_q    <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            en_q    <= en_d;
            div_q   <= div_d;
            rv_q    <= rv_d;
            rdy_q   <= rdy_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (acc && bus_io.sof) ? (bus_io.eof ? DONE : ACCUM) : IDLE;
            ACCUM:   state_d = (acc && bus_io.eof) ? DONE : ACCUM;
            default: state_d = IDLE;
        endcase
    end
    // Result fields hold after DONE until the next accepted sof
    always_comb begin
        rem_d = rem_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        en_d  = en_q;
        div_d = div_q;
        rv_d  = 1'b0;
        rdy_d = state_d != DONE;
        if (state_q == DONE) begin
            rv_d  = 1'b1;
            en_d  = 1'b1;
            div_d = rem_q[0];
        end else if (acc && bus_io.sof) begin
            rem_d = bus_io.bit_in ? 8'h02 : 8'h01;
            cnt_d = CNT_W'(1);
            ovf_d = 1'b0;
            en_d  = 1'b0;
            div_d = 1'b0;
        end else if (acc && state_q == ACCUM) begin
            rem_d = next_rem(rem_q, bus_io.bit_in);
            cnt_d = sat ? cnt_q : cnt_q + CNT_W'(1);
            ovf_d = ovf_q | sat;
        end
    end
    assign bus_io.rem_onehot   = rem_q;
    assign bus_io.bit_count    = cnt_q;
    assign bus_io.overflow     = ovf_q;
    assign bus_io.rem_en       = en_q;
    assign bus_io.divisible    = div_q;
    assign bus_io.result_valid = rv_q;
    assign bus_io.bit_ready    = rdy_q;
endmodule

// File: tb/tb_mod5_onehot_tracker.sv
// tb_mod5_onehot_tracker: directed bench for mod5_onehot_tracker built with MAX_BITS=4.
// Drives frames through the master modport and compares outputs with hand-computed values.
module tb_mod5_onehot_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   rv_cnt = 0;
    int   rv_base;
    mod5_onehot_tracker_if #(.CNT_W(6)) bus ();
    mod5_onehot_tracker #(.MAX_BITS(4), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (bus.result_valid) rv_cnt++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic b, input logic s, input logic e);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        bus.sof       = s;
        bus.eof       = e;
        step();
        bus.bit_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.eof       = 1'b0;
    endtask
    initial begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.sof       = 1'b0;
        bus.eof       = 1'b0;
        step();
        step();
        rst = 1'b0;
        // 1: reset in the middle of a frame
        send(1, 1, 0);
        send(1, 0, 0);
        check("pre_rst_rem", bus.rem_onehot, 8'h08);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_rem", bus.rem_onehot, 8'h01);
        check("rst_en", bus.rem_en, 0);
        check("rst_rv", bus.result_valid, 0);
        check("rst_div", bus.divisible, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_cnt", bus.bit_count, 0);
        check("rst_rdy", bus.bit_ready, 1);
        step();
        step();
        check("rst_no_rv", rv_cnt, 0);
        // 2: frame 1010 = 10
        send(1, 1, 0);
        check("f10_rem1", bus.rem_onehot, 8'h02);
        check("f10_en_acc", bus.rem_en, 0);
        send(0, 0, 0);
        send(1, 0, 0);
        send(0, 0, 1);
        check("f10_rdy_done", bus.bit_ready, 0);
        check("f10_rv_early", bus.result_valid, 0);
        step();
        check("f10_rv", bus.result_valid, 1);
        check("f10_rem", bus.rem_onehot, 8'h01);
        check("f10_div", bus.divisible, 1);
        check("f10_cnt", bus.bit_count, 4);
        check("f10_en", bus.rem_en, 1);
        step();
        check("f10_rv_off", bus.result_valid, 0);
        check("f10_rem_hold", bus.rem_onehot, 8'h01);
        check("f10_en_hold", bus.rem_en, 1);
        check("f10_rdy", bus.bit_ready, 1);
        // 3: frame 111 = 7 with gaps, bit offered during DONE
        send(1, 1, 0);
        step();
        step();
        check("f7_gap_rem", bus.rem_onehot, 8'h02);
        check("f7_gap_cnt", bus.bit_count, 1);
        send(1, 0, 0);
        step();
        step();
        step();
        send(1, 0, 1);
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        bus.sof       = 1'b1;
        bus.eof       = 1'b1;
        check("f7_rdy_done", bus.bit_ready, 0);
        step();
        bus.bit_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.eof       = 1'b0;
        check("f7_rv", bus.result_valid, 1);
        check("f7_rem", bus.rem_onehot, 8'h04);
        check("f7_div", bus.divisible, 0);
        check("f7_cnt", bus.bit_count, 3);
        step();
        check("f7_done_bit_rem", bus.rem_onehot, 8'h04);
        check("f7_done_bit_cnt", bus.bit_count, 3);
        // 4: stray bits in IDLE, then a one-bit frame
        rv_base = rv_cnt;
        send(1, 0, 0);
        send(0, 0, 1);
        step();
        check("idle_drop_rem", bus.rem_onehot, 8'h04);
        check("idle_drop_cnt", bus.bit_count, 3);
        check("idle_drop_rv", rv_cnt - rv_base, 0);
        send(1, 1, 1);
        check("one_rdy_done", bus.bit_ready, 0);
        step();
        check("one_rv", bus.result_valid, 1);
        check("one_rem", bus.rem_onehot, 8'h02);
        check("one_cnt", bus.bit_count, 1);
        check("one_div", bus.divisible, 0);
        step();
        // 5: restart mid-frame, final frame 100 = 4
        rv_base = rv_cnt;
        send(1, 1, 0);
        send(1, 0, 0);
        check("rs_part_rem", bus.rem_onehot, 8'h08);
        send(1, 1, 0);
        check("rs_restart_cnt", bus.bit_count, 1);
        send(0, 0, 0);
        send(0, 0, 1);
        step();
        check("rs_rv", bus.result_valid, 1);
        check("rs_rem", bus.rem_onehot, 8'h10);
        check("rs_cnt", bus.bit_count, 3);
        step();
        step();
        check("rs_one_rv", rv_cnt - rv_base, 1);
        // 6: 110010 = 50 overflows MAX_BITS=4
        send(1, 1, 0);
        send(1, 0, 0);
        send(0, 0, 0);
        send(0, 0, 0);
        check("ov_cnt4", bus.bit_count, 4);
        check("ov_not_yet", bus.overflow, 0);
        send(1, 0, 0);
        check("ov_set", bus.overflow, 1);
        send(0, 0, 1);
        step();
        check("ov_rv", bus.result_valid, 1);
        check("ov_ovf", bus.overflow, 1);
        check("ov_cnt", bus.bit_count, 4);
        check("ov_rem", bus.rem_onehot, 8'h01);
        check("ov_div", bus.divisible, 1);
        step();
        send(0, 1, 0);
        check("ov_clr", bus.overflow, 0);
        check("ov_clr_cnt", bus.bit_count, 1);
        check("ov_clr_en", bus.rem_en, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod5_onehot_tracker.md
Name: mod5_onehot_tracker

Overview:
- Serial front end of the modulo-5 detector.
- Consumes a framed bit stream, MSB first, with a valid/ready handshake.
- Tracks the running remainder (value mod 5) as a one-hot state vector.
- Drives the one-hot vector and enable directly into the downstream 8-to-3 encoder, which produces the binary remainder. It also flags divisibility and frame statistics.

Parameters:
MAX_BITS, 32, maximum counted bits per frame; further bits set overflow.
CNT_W, 6, width of bit_count; must satisfy 2**CNT_W > MAX_BITS.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
bit_valid  input  1  bit_in/sof/eof qualified.
bit_in  input  1  serial data bit, MSB first.
sof  input  1  accepted bit is first of frame.
eof  input  1  accepted bit is last of frame.
bit_ready  output  1  block can accept a bit this cycle.
rem_onehot  output  8  one-hot remainder; bit k set means remainder k; feeds encoder in.
rem_en  output  1  feeds encoder en; high only while rem_onehot holds a completed result.
result_valid  output  1  one-cycle pulse, frame result ready.
divisible  output  1  completed frame value mod 5 == 0.
overflow  output  1  frame exceeded MAX_BITS bits.
bit_count  output  CNT_W  bits accepted in current/last frame, saturating at MAX_BITS.

Behaviour:
- All outputs registered; clock and reset as stated above.
- Reset values: state IDLE, rem_onehot=8'h01, rem_en=0, result_valid=0, divisible=0, overflow=0, bit_count=0, bit_ready=1.
- Reset mid-frame abandons the frame; no result_valid is produced for it.
- Accept rule: a bit is accepted on an edge where bit_valid && bit_ready. bit_ready=1 in IDLE/ACCUM, 0 in DONE.
- Remainder update: r' = (2r + b) mod 5. One-hot transitions (r: b=0 / b=1):
  - 0: 0/1
  - 1: 2/3
  - 2: 4/0
  - 3: 1/2
  - 4: 3/4
- rem_onehot[7:5] are always 0; exactly one of [4:0] is set at all times.
- FSM IDLE:
  - Accepted bit without sof: dropped; no state change.
  - Accepted bit with sof: rem_onehot=1<<bit_in, bit_count=1, overflow=0, rem_en=0, divisible=0.
  - Next state: ACCUM, or DONE if eof is also set.
- FSM ACCUM:
  - Accepted bit with sof: restart the frame exactly as from IDLE; the partial frame is discarded.
  - Accepted bit without sof: apply the remainder update.
  - bit_count increments while below MAX_BITS. If bit_count==MAX_BITS already, overflow is set sticky and the count holds; the remainder still updates exactly.
  - eof on an accepted bit: go to DONE. If sof and eof are both set, it is a one-bit frame.
  - Cycles with no accepted bit hold all state.
- FSM DONE (exactly one cycle):
  - result_valid=1, rem_en=1, divisible=rem_onehot[0].
  - Any bit presented is not accepted.
  - Next state: IDLE.
- After DONE:
  - result_valid returns to 0.
  - rem_onehot, rem_en, divisible, overflow and bit_count hold until the next sof is accepted.
- Latency: eof bit accepted on edge N gives result_valid=1 for the cycle following edge N+1, with the final remainder.
- Downstream view: the encoder sees en=0 during accumulation (output 3'b000) and the valid one-hot whenever rem_en=1.

Test Plan:
1. Reset:
   - Assert rst for 2 cycles mid-frame.
   - Required: all outputs at reset values, bit_ready=1, no result_valid.
2. Frame 1,0,1,0 (decimal 10):
   - sof on the first bit, eof on the last, back-to-back valid.
   - Required: result_valid pulse one cycle after the eof edge, rem_onehot=8'h01, divisible=1, bit_count=4, encoder output 3'b000.
3. Frame 1,1,1 (7) with bit_valid gaps of 0-3 cycles:
   - Required: rem_onehot=8'h04, divisible=0, bit_count=3.
   - A bit offered during DONE stays unaccepted (bit_ready=0).
4. Single-bit frame, sof+eof with bit_in=1, from IDLE:
   - Required: direct IDLE->DONE, rem_onehot=8'h02, bit_count=1.
   - Bits sent in IDLE without sof beforehand are ignored.
5. Restart:
   - Send 1,1 (sof on the first), then sof 1,0,0 eof (4).
   - Required: rem_onehot=8'h10, bit_count=3, exactly one result_valid.
6. MAX_BITS=4, frame 1,1,0,0,1,0 (50):
   - Required: overflow=1, bit_count=4, rem_onehot=8'h01, divisible=1.
   - The next frame's sof clears overflow to 0.
